// File: rtl/decode_pkg.sv
// Shared decode definitions: opcode/funct constants, ALU op encoding,
// packed control word and branch-kind enum for decode_stage_p.
package decode_pkg;

    localparam int CTRL_W = 11;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_BLEZ  = 6'h06;
    localparam logic [5:0] OP_BGTZ  = 6'h07;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] FN_JR      = 6'h08;
    localparam logic [5:0] FN_SYSCALL = 6'h0c;
    localparam logic [5:0] FN_ADD     = 6'h20;
    localparam logic [5:0] FN_SUB     = 6'h22;
    localparam logic [5:0] FN_AND     = 6'h24;
    localparam logic [5:0] FN_OR      = 6'h25;
    localparam logic [5:0] FN_SLT     = 6'h2a;

    typedef enum logic [2:0] {
        ALU_AND = 3'b000,
        ALU_OR  = 3'b001,
        ALU_ADD = 3'b010,
        ALU_SUB = 3'b110,
        ALU_SLT = 3'b111
    } alu_op_e;

    // MSB first: regwrite down to alu_ctrl[2:0]
    typedef struct packed {
        logic    regwrite;
        logic    memtoreg;
        logic    memwrite;
        logic    memread;
        logic    alusrc;
        logic    regdst;
        logic    link;
        logic    syscall;
        alu_op_e alu_ctrl;
    } ctrl_t;

    typedef enum logic [2:0] {
        BR_NONE,
        BR_BEQ,
        BR_BNE,
        BR_BLEZ,
        BR_BGTZ,
        BR_J,
        BR_JR
    } br_kind_e;

    // Pseudo-direct jump target inside the current 256 MB region
    function automatic logic [31:0] jump_target(input logic [31:0] pc4, input logic [25:0] idx);
        return {pc4[31:28], idx, 2'b00};
    endfunction

endpackage

// File: rtl/decode_stage_p_if.sv
// Fetch-to-decode valid/ready channel. master = fetch side, slave = decode side.
interface decode_stage_p_if #(
    parameter int DATA_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_instr;
    logic [DATA_W-1:0] in_pc4;

    modport master (output in_valid, output in_instr, output in_pc4, input in_ready);
    modport slave  (input in_valid, input in_instr, input in_pc4, output in_ready);
endinterface

// File: rtl/decode_stage_p_regfile_2r1w.sv
// Two-read one-write register file, async-reset storage, combinational reads.
// Optional macro DECODE_SYSCALL_TAP_EN exposes live r2/r4 values.
module regfile_2r1w #(
    parameter int  NUM_REGS = 32,
    parameter int  DATA_W   = 32,
    parameter int  ZERO_REG = 1,
    localparam int AW       = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr_a,
    input  logic [AW-1:0]     raddr_b,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b
`ifdef DECODE_SYSCALL_TAP_EN
    ,
    output logic [DATA_W-1:0] tap_v0,
    output logic [DATA_W-1:0] tap_a0
`endif
);

    logic [DATA_W-1:0] regs [NUM_REGS];

    // Storage write; r0 stays at its reset value of zero when hard-wired
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (we && !((ZERO_REG != 0) && (waddr == '0))) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata_a = regs[raddr_a];
    assign rdata_b = regs[raddr_b];

`ifdef DECODE_SYSCALL_TAP_EN
    assign tap_v0 = regs[2];
    assign tap_a0 = regs[4];
`endif

endmodule

// File: rtl/decode_stage_p.sv
// MIPS decode stage: register read with MEM/WB forwarding, in-decode branch
// and jump resolution, internal hazard detection and a registered ID/EX slot.
// Optional macro DECODE_SYSCALL_TAP_EN adds dbg_v0/dbg_a0 and syscall_evt.
module decode_stage_p
    import decode_pkg::*;
#(
    parameter int  DATA_W   = 32,
    parameter int  NUM_REGS = 32,
    parameter int  ZERO_REG = 1,
    localparam int AW       = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    decode_stage_p_if.slave   fetch,
    input  logic              wb_we,
    input  logic [AW-1:0]     wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              mem_fwd_we,
    input  logic [AW-1:0]     mem_fwd_addr,
    input  logic [DATA_W-1:0] mem_fwd_data,
    input  logic              ex_is_load,
    input  logic              ex_we,
    input  logic [AW-1:0]     ex_dst,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] ex_rs_data,
    output logic [DATA_W-1:0] ex_rt_data,
    output logic [DATA_W-1:0] ex_imm,
    output logic [DATA_W-1:0] ex_link_data,
    output logic [AW-1:0]     ex_rs,
    output logic [AW-1:0]     ex_rt,
    output logic [AW-1:0]     ex_rd,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic              illegal_instr,
    output logic              redirect,
    output logic [DATA_W-1:0] redirect_pc
`ifdef DECODE_SYSCALL_TAP_EN
    ,
    output logic [DATA_W-1:0] dbg_v0,
    output logic [DATA_W-1:0] dbg_a0,
    output logic              syscall_evt
`endif
);

    // jal links into the top register when the file is narrower than 32
    localparam logic [AW-1:0] LINK_REG = AW'(NUM_REGS - 1);

    logic [31:0]       instr;
    logic [5:0]        opcode, funct;
    logic [4:0]        rs_f, rt_f, rd_f;
    logic [AW-1:0]     rs_idx, rt_idx, rd_idx;
    logic [DATA_W-1:0] imm_sext, rf_rs, rf_rt, rs_val, rt_val;
    logic [DATA_W-1:0] br_target, target, link_val;
    logic              rs_zero, rt_zero, uses_rs, uses_rt, legal, taken;
    logic              is_branch, ex_dst_live, load_use, br_hazard, stall;
    logic              slot_free, accept;
    ctrl_t             ctrl;
    br_kind_e          br_kind;

    assign instr    = fetch.in_instr;
    assign opcode   = instr[31:26];
    assign funct    = instr[5:0];
    assign rs_f     = instr[25:21];
    assign rt_f     = instr[20:16];
    assign rd_f     = instr[15:11];
    assign rs_idx   = rs_f[AW-1:0];
    assign rt_idx   = rt_f[AW-1:0];
    assign rd_idx   = (opcode == OP_JAL) ? LINK_REG : rd_f[AW-1:0];
    assign imm_sext = {{(DATA_W-16){instr[15]}}, instr[15:0]};
    assign link_val = fetch.in_pc4 + DATA_W'(4);

    regfile_2r1w #(.NUM_REGS(NUM_REGS), .DATA_W(DATA_W), .ZERO_REG(ZERO_REG)) u_rf (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (wb_we),
        .waddr   (wb_addr),
        .wdata   (wb_data),
        .raddr_a (rs_idx),
        .raddr_b (rt_idx),
        .rdata_a (rf_rs),
        .rdata_b (rf_rt)
`ifdef DECODE_SYSCALL_TAP_EN
        ,
        .tap_v0  (dbg_v0),
        .tap_a0  (dbg_a0)
`endif
    );

    // MEM result beats the same-cycle WB bypass; a hard-wired r0 never forwards
    assign rs_zero = (ZERO_REG != 0) && (rs_idx == '0);
    assign rt_zero = (ZERO_REG != 0) && (rt_idx == '0);
    assign rs_val  = (mem_fwd_we && mem_fwd_addr == rs_idx && !rs_zero) ? mem_fwd_data :
                     (wb_we && wb_addr == rs_idx && !rs_zero) ? wb_data : rf_rs;
    assign rt_val  = (mem_fwd_we && mem_fwd_addr == rt_idx && !rt_zero) ? mem_fwd_data :
                     (wb_we && wb_addr == rt_idx && !rt_zero) ? wb_data : rf_rt;

    // Instruction decode into control word, branch kind and source usage
    always_comb begin
        ctrl    = '0;
        br_kind = BR_NONE;
        uses_rs = 1'b0;
        uses_rt = 1'b0;
        legal   = 1'b1;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: begin
                        ctrl.regwrite = 1'b1;
                        ctrl.regdst   = 1'b1;
                        uses_rs       = 1'b1;
                        uses_rt       = 1'b1;
                        case (funct)
                            FN_ADD:  ctrl.alu_ctrl = ALU_ADD;
                            FN_SUB:  ctrl.alu_ctrl = ALU_SUB;
                            FN_AND:  ctrl.alu_ctrl = ALU_AND;
                            FN_OR:   ctrl.alu_ctrl = ALU_OR;
                            default: ctrl.alu_ctrl = ALU_SLT;
                        endcase
                    end
                    FN_JR: begin
                        br_kind = BR_JR;
                        uses_rs = 1'b1;
                    end
                    FN_SYSCALL: begin
`ifdef DECODE_SYSCALL_TAP_EN
                        ctrl.syscall = 1'b1;
`endif
                    end
                    default: legal = 1'b0;
                endcase
            end
            OP_LW: begin
                ctrl.regwrite = 1'b1;
                ctrl.memtoreg = 1'b1;
                ctrl.memread  = 1'b1;
                ctrl.alusrc   = 1'b1;
                ctrl.alu_ctrl = ALU_ADD;
                uses_rs       = 1'b1;
            end
            OP_SW: begin
                ctrl.memwrite = 1'b1;
                ctrl.alusrc   = 1'b1;
                ctrl.alu_ctrl = ALU_ADD;
                uses_rs       = 1'b1;
                uses_rt       = 1'b1;
            end
            OP_ADDI: begin
                ctrl.regwrite = 1'b1;
                ctrl.alusrc   = 1'b1;
                ctrl.alu_ctrl = ALU_ADD;
                uses_rs       = 1'b1;
            end
            OP_ORI: begin
                ctrl.regwrite = 1'b1;
                ctrl.alusrc   = 1'b1;
                ctrl.alu_ctrl = ALU_OR;
                uses_rs       = 1'b1;
            end
            OP_BEQ:  begin br_kind = BR_BEQ;  uses_rs = 1'b1; uses_rt = 1'b1; end
            OP_BNE:  begin br_kind = BR_BNE;  uses_rs = 1'b1; uses_rt = 1'b1; end
            OP_BLEZ: begin br_kind = BR_BLEZ; uses_rs = 1'b1; end
            OP_BGTZ: begin br_kind = BR_BGTZ; uses_rs = 1'b1; end
            OP_J:    br_kind = BR_J;
            OP_JAL: begin
                br_kind       = BR_J;
                ctrl.regwrite = 1'b1;
                ctrl.link     = 1'b1;
            end
            default: legal = 1'b0;
        endcase
    end

    // Hazards: load-use on any used source; any in-flight write to a branch/jr operand
    assign is_branch   = br_kind inside {BR_BEQ, BR_BNE, BR_BLEZ, BR_BGTZ, BR_JR};
    assign ex_dst_live = ex_we && (ex_dst != '0);
    assign load_use    = ex_is_load && ex_dst_live &&
                         ((uses_rs && ex_dst == rs_idx) || (uses_rt && ex_dst == rt_idx));
    assign br_hazard   = is_branch && ex_dst_live && (ex_dst == rs_idx || ex_dst == rt_idx);
    assign stall       = load_use | br_hazard;

    assign slot_free      = !out_valid | out_ready;
    assign fetch.in_ready = slot_free & !stall & !flush;
    assign accept         = fetch.in_valid & fetch.in_ready;

    // Branch condition and target selection on forwarded operands
    always_comb begin
        taken = 1'b0;
        case (br_kind)
            BR_BEQ:       taken = (rs_val == rt_val);
            BR_BNE:       taken = (rs_val != rt_val);
            BR_BLEZ:      taken = rs_val[DATA_W-1] || (rs_val == '0);
            BR_BGTZ:      taken = !rs_val[DATA_W-1] && (rs_val != '0);
            BR_J, BR_JR:  taken = 1'b1;
            default:      taken = 1'b0;
        endcase
    end

    assign br_target = fetch.in_pc4 + (imm_sext << 2);
    assign target    = (br_kind == BR_J)  ? DATA_W'(jump_target(fetch.in_pc4[31:0], instr[25:0])) :
                       (br_kind == BR_JR) ? rs_val : br_target;

    assign redirect    = accept & taken;
    assign redirect_pc = target;

    // ID/EX slot: flush empties it, a free slot loads or bubbles, a busy slot holds
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid     <= 1'b0;
            illegal_instr <= 1'b0;
            ex_rs_data    <= '0;
            ex_rt_data    <= '0;
            ex_imm        <= '0;
            ex_link_data  <= '0;
            ex_rs         <= '0;
            ex_rt         <= '0;
            ex_rd         <= '0;
            ex_ctrl       <= '0;
        end else if (flush) begin
            out_valid     <= 1'b0;
            illegal_instr <= 1'b0;
        end else if (slot_free) begin
            out_valid     <= accept;
            illegal_instr <= accept & !legal;
            if (accept) begin
                ex_rs_data   <= rs_val;
                ex_rt_data   <= rt_val;
                ex_imm       <= imm_sext;
                ex_link_data <= link_val;
                ex_rs        <= rs_idx;
                ex_rt        <= rt_idx;
                ex_rd        <= rd_idx;
                ex_ctrl      <= ctrl;
            end
        end
    end

`ifdef DECODE_SYSCALL_TAP_EN
    // One-cycle pulse for each accepted syscall
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) syscall_evt <= 1'b0;
        else        syscall_evt <= accept & ctrl.syscall;
    end
`endif

endmodule

// File: tb/tb_decode_stage_p.sv
// Directed, table-driven bench for decode_stage_p (DATA_W=32, NUM_REGS=32, ZERO_REG=1).
module tb_decode_stage_p;

    localparam int DATA_W = 32;
    localparam int AW     = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    decode_stage_p_if #(.DATA_W(DATA_W)) fif ();

    logic              wb_we, mem_fwd_we, ex_is_load, ex_we, flush, out_ready;
    logic [AW-1:0]     wb_addr, mem_fwd_addr, ex_dst;
    logic [DATA_W-1:0] wb_data, mem_fwd_data;
    logic              out_valid, illegal_instr, redirect;
    logic [DATA_W-1:0] ex_rs_data, ex_rt_data, ex_imm, ex_link_data, redirect_pc;
    logic [AW-1:0]     ex_rs, ex_rt, ex_rd;
    logic [10:0]       ex_ctrl;
`ifdef DECODE_SYSCALL_TAP_EN
    logic [DATA_W-1:0] dbg_v0, dbg_a0;
    logic              syscall_evt;
    localparam logic [10:0] SYS_CTRL = 11'h008;
`else
    localparam logic [10:0] SYS_CTRL = 11'h000;
`endif

    decode_stage_p #(.DATA_W(DATA_W), .NUM_REGS(32), .ZERO_REG(1)) dut (
        .clk(clk), .rst_n(rst_n), .fetch(fif),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .mem_fwd_we(mem_fwd_we), .mem_fwd_addr(mem_fwd_addr), .mem_fwd_data(mem_fwd_data),
        .ex_is_load(ex_is_load), .ex_we(ex_we), .ex_dst(ex_dst), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm),
        .ex_link_data(ex_link_data), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
        .ex_ctrl(ex_ctrl), .illegal_instr(illegal_instr),
        .redirect(redirect), .redirect_pc(redirect_pc)
`ifdef DECODE_SYSCALL_TAP_EN
        , .dbg_v0(dbg_v0), .dbg_a0(dbg_a0), .syscall_evt(syscall_evt)
`endif
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] r_ins(input int rs, input int rt, input int rd, input logic [5:0] fn);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
    endfunction
    function automatic logic [31:0] i_ins(input logic [5:0] op, input int rs, input int rt, input logic [15:0] imm);
        return {op, 5'(rs), 5'(rt), imm};
    endfunction
    function automatic logic [31:0] j_ins(input logic [5:0] op, input logic [25:0] idx);
        return {op, idx};
    endfunction

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        redir;
        logic [31:0] rpc;
        logic [31:0] rs_d;
        logic [31:0] rt_d;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [10:0] ctrl;
        logic        ill;
    } vec_t;

    vec_t vecs[$];

    task automatic addv(input logic [31:0] instr, input logic [31:0] pc4, input logic redir,
                        input logic [31:0] rpc, input logic [31:0] rs_d, input logic [31:0] rt_d,
                        input logic [31:0] imm, input logic [4:0] rd, input logic [10:0] ctrl,
                        input logic ill);
        vec_t v;
        v.instr = instr; v.pc4 = pc4; v.redir = redir; v.rpc = rpc; v.rs_d = rs_d;
        v.rt_d = rt_d; v.imm = imm; v.rd = rd; v.ctrl = ctrl; v.ill = ill;
        vecs.push_back(v);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        fif.in_valid = 1'b0; fif.in_instr = '0; fif.in_pc4 = '0;
        wb_we = 1'b0; wb_addr = '0; wb_data = '0;
        mem_fwd_we = 1'b0; mem_fwd_addr = '0; mem_fwd_data = '0;
        ex_is_load = 1'b0; ex_we = 1'b0; ex_dst = '0;
        flush = 1'b0; out_ready = 1'b1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        wb_we = 1'b1; wb_addr = a; wb_data = d;
        tick();
        wb_we = 1'b0;
    endtask

    task automatic present(input logic [31:0] instr, input logic [31:0] pc4);
        fif.in_valid = 1'b1; fif.in_instr = instr; fif.in_pc4 = pc4;
    endtask

    initial begin
        idle();
        // reset
        #2 rst_n = 1'b0;
        #10;
        chk("rst.out_valid", 32'(out_valid), 32'd0);
        chk("rst.illegal", 32'(illegal_instr), 32'd0);
        chk("rst.ex_ctrl", 32'(ex_ctrl), 32'd0);
        chk("rst.ex_rs_data", ex_rs_data, 32'd0);
        chk("rst.ex_imm", ex_imm, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        tick();

        wr(5'd1, 32'h0000000A);
        wr(5'd2, 32'h00000014);
        wr(5'd6, 32'hFFFFFFFF);
        wr(5'd7, 32'h00000007);
        wr(5'd9, 32'h00001234);
        wr(5'd10, 32'h00001234);

        //    instr                          pc4          rdr rpc          rs_d         rt_d         imm          rd  ctrl    ill
        addv(r_ins(1, 2, 5, 6'h20),         32'h1000,    0, 32'h0,        32'hA,       32'h14,      32'h2820,     5, 11'h422, 0);
        addv(r_ins(2, 1, 5, 6'h22),         32'h1000,    0, 32'h0,        32'h14,      32'hA,       32'h2822,     5, 11'h426, 0);
        addv(r_ins(1, 2, 5, 6'h24),         32'h1000,    0, 32'h0,        32'hA,       32'h14,      32'h2824,     5, 11'h420, 0);
        addv(r_ins(1, 2, 5, 6'h25),         32'h1000,    0, 32'h0,        32'hA,       32'h14,      32'h2825,     5, 11'h421, 0);
        addv(r_ins(6, 7, 5, 6'h2a),         32'h1000,    0, 32'h0,        32'hFFFFFFFF,32'h7,       32'h282A,     5, 11'h427, 0);
        addv(i_ins(6'h23, 1, 8, 16'hFFFC),  32'h1000,    0, 32'h0,        32'hA,       32'h0,       32'hFFFFFFFC,31, 11'h6C2, 0);
        addv(i_ins(6'h2b, 1, 2, 16'h0008),  32'h1000,    0, 32'h0,        32'hA,       32'h14,      32'h8,        0, 11'h142, 0);
        addv(i_ins(6'h08, 1, 5, 16'hFFFF),  32'h1000,    0, 32'h0,        32'hA,       32'h0,       32'hFFFFFFFF,31, 11'h442, 0);
        addv(i_ins(6'h0d, 1, 5, 16'h00F0),  32'h1000,    0, 32'h0,        32'hA,       32'h0,       32'hF0,       0, 11'h441, 0);
        addv(i_ins(6'h04, 9, 10, 16'h0004), 32'h1000,    1, 32'h1010,     32'h1234,    32'h1234,    32'h4,        0, 11'h000, 0);
        addv(i_ins(6'h05, 9, 10, 16'h0004), 32'h1000,    0, 32'h0,        32'h1234,    32'h1234,    32'h4,        0, 11'h000, 0);
        addv(i_ins(6'h04, 1, 2, 16'hFFFF),  32'h1000,    0, 32'h0,        32'hA,       32'h14,      32'hFFFFFFFF,31, 11'h000, 0);
        addv(i_ins(6'h05, 1, 2, 16'hFFFE),  32'h1000,    1, 32'h0FF8,     32'hA,       32'h14,      32'hFFFFFFFE,31, 11'h000, 0);
        addv(i_ins(6'h07, 6, 0, 16'h0004),  32'h1000,    0, 32'h0,        32'hFFFFFFFF,32'h0,       32'h4,        0, 11'h000, 0);
        addv(i_ins(6'h06, 6, 0, 16'h0004),  32'h1000,    1, 32'h1010,     32'hFFFFFFFF,32'h0,       32'h4,        0, 11'h000, 0);
        addv(i_ins(6'h07, 1, 0, 16'h0002),  32'h1000,    1, 32'h1008,     32'hA,       32'h0,       32'h2,        0, 11'h000, 0);
        addv(i_ins(6'h06, 0, 0, 16'h0001),  32'h1000,    1, 32'h1004,     32'h0,       32'h0,       32'h1,        0, 11'h000, 0);
        addv(j_ins(6'h02, 26'h0000400),     32'h10000004,1, 32'h10001000, 32'h0,       32'h0,       32'h400,      0, 11'h000, 0);
        addv(j_ins(6'h03, 26'h0100000),     32'h00400004,1, 32'h00400000, 32'h0,       32'h0,       32'h0,       31, 11'h410, 0);
        addv(r_ins(7, 0, 0, 6'h08),         32'h1000,    1, 32'h7,        32'h7,       32'h0,       32'h8,        0, 11'h000, 0);
        addv(r_ins(0, 0, 0, 6'h0c),         32'h1000,    0, 32'h0,        32'h0,       32'h0,       32'hC,        0, SYS_CTRL,0);
        addv(i_ins(6'h3f, 0, 0, 16'h0000),  32'h1000,    0, 32'h0,        32'h0,       32'h0,       32'h0,        0, 11'h000, 1);
        addv(r_ins(1, 2, 5, 6'h21),         32'h1000,    0, 32'h0,        32'hA,       32'h14,      32'h2821,     5, 11'h000, 1);

        foreach (vecs[i]) begin
            present(vecs[i].instr, vecs[i].pc4);
            @(negedge clk);
            chk($sformatf("v%0d.in_ready", i), 32'(fif.in_ready), 32'd1);
            chk($sformatf("v%0d.redirect", i), 32'(redirect), 32'(vecs[i].redir));
            if (vecs[i].redir) chk($sformatf("v%0d.redirect_pc", i), redirect_pc, vecs[i].rpc);
            tick();
            chk($sformatf("v%0d.out_valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("v%0d.rs_data", i), ex_rs_data, vecs[i].rs_d);
            chk($sformatf("v%0d.rt_data", i), ex_rt_data, vecs[i].rt_d);
            chk($sformatf("v%0d.imm", i), ex_imm, vecs[i].imm);
            chk($sformatf("v%0d.rd", i), 32'(ex_rd), 32'(vecs[i].rd));
            chk($sformatf("v%0d.ctrl", i), 32'(ex_ctrl), 32'(vecs[i].ctrl));
            chk($sformatf("v%0d.illegal", i), 32'(illegal_instr), 32'(vecs[i].ill));
            if (vecs[i].ctrl[4]) chk($sformatf("v%0d.link", i), ex_link_data, vecs[i].pc4 + 32'd4);
        end

        // same-cycle WB bypass, MEM-over-WB priority, r0 never forwards
        present(r_ins(3, 3, 4, 6'h20), 32'h1000);
        wb_we = 1'b1; wb_addr = 5'd3; wb_data = 32'h55;
        tick();
        chk("byp.rs", ex_rs_data, 32'h55);
        chk("byp.rt", ex_rt_data, 32'h55);
        present(r_ins(3, 1, 4, 6'h20), 32'h1000);
        wb_data = 32'h77;
        mem_fwd_we = 1'b1; mem_fwd_addr = 5'd3; mem_fwd_data = 32'h66;
        tick();
        chk("prio.rs", ex_rs_data, 32'h66);
        chk("prio.rt", ex_rt_data, 32'hA);
        wb_we = 1'b0; mem_fwd_we = 1'b0;
        present(r_ins(3, 3, 4, 6'h20), 32'h1000);
        tick();
        chk("rf.r3", ex_rs_data, 32'h77);
        wb_we = 1'b1; wb_addr = 5'd0; wb_data = 32'h88;
        mem_fwd_we = 1'b1; mem_fwd_addr = 5'd0; mem_fwd_data = 32'h99;
        present(r_ins(0, 0, 4, 6'h20), 32'h1000);
        tick();
        chk("r0fwd.rs", ex_rs_data, 32'h0);
        chk("r0fwd.rt", ex_rt_data, 32'h0);
        wb_we = 1'b0; mem_fwd_we = 1'b0;
        present(r_ins(0, 3, 4, 6'h20), 32'h1000);
        tick();
        chk("r0wr.rs", ex_rs_data, 32'h0);

        // load-use on a branch operand, then resolve via MEM forwarding
        ex_is_load = 1'b1; ex_we = 1'b1; ex_dst = 5'd8;
        present(i_ins(6'h04, 8, 9, 16'h0003), 32'h2000);
        @(negedge clk);
        chk("lu.in_ready", 32'(fif.in_ready), 32'd0);
        chk("lu.redirect", 32'(redirect), 32'd0);
        tick();
        chk("lu.bubble", 32'(out_valid), 32'd0);
        ex_is_load = 1'b0; ex_we = 1'b0; ex_dst = '0;
        mem_fwd_we = 1'b1; mem_fwd_addr = 5'd8; mem_fwd_data = 32'h1234;
        @(negedge clk);
        chk("lu2.in_ready", 32'(fif.in_ready), 32'd1);
        chk("lu2.redirect", 32'(redirect), 32'd1);
        chk("lu2.redirect_pc", redirect_pc, 32'h200C);
        tick();
        chk("lu2.out_valid", 32'(out_valid), 32'd1);
        chk("lu2.rs_data", ex_rs_data, 32'h1234);
        mem_fwd_we = 1'b0;
        // ALU result in EX: stalls a branch on it, not an ALU consumer
        ex_we = 1'b1; ex_dst = 5'd9;
        present(i_ins(6'h04, 1, 9, 16'h0001), 32'h2000);
        @(negedge clk);
        chk("brh.in_ready", 32'(fif.in_ready), 32'd0);
        present(r_ins(1, 9, 4, 6'h20), 32'h2000);
        #2;
        chk("alu.in_ready", 32'(fif.in_ready), 32'd1);
        tick();
        ex_is_load = 1'b1; ex_dst = 5'd2;
        present(i_ins(6'h2b, 1, 2, 16'h0008), 32'h2000);
        @(negedge clk);
        chk("lu_sw.in_ready", 32'(fif.in_ready), 32'd0);
        ex_dst = 5'd0;
        present(r_ins(0, 0, 4, 6'h20), 32'h2000);
        #2;
        chk("lu_r0.in_ready", 32'(fif.in_ready), 32'd1);
        tick();
        ex_is_load = 1'b0; ex_we = 1'b0;

        // backpressure holds the slot; flush empties it despite out_ready=0
        present(r_ins(1, 2, 5, 6'h20), 32'h3000);
        tick();
        out_ready = 1'b0;
        present(r_ins(2, 1, 5, 6'h22), 32'h3000);
        @(negedge clk);
        chk("hold.in_ready", 32'(fif.in_ready), 32'd0);
        tick();
        chk("hold.out_valid", 32'(out_valid), 32'd1);
        chk("hold.ctrl", 32'(ex_ctrl), 32'h422);
        chk("hold.rs_data", ex_rs_data, 32'hA);
        flush = 1'b1;
        present(i_ins(6'h04, 9, 10, 16'h0004), 32'h3000);
        @(negedge clk);
        chk("flush.in_ready", 32'(fif.in_ready), 32'd0);
        chk("flush.redirect", 32'(redirect), 32'd0);
        tick();
        chk("flush.out_valid", 32'(out_valid), 32'd0);
        flush = 1'b0;
        fif.in_valid = 1'b0;
        tick();
        chk("flush2.out_valid", 32'(out_valid), 32'd0);
        out_ready = 1'b1;

        // reset mid-stream clears the slot immediately and the register file
        wr(5'd5, 32'hABC);
        present(r_ins(5, 5, 4, 6'h20), 32'h4000);
        tick();
        chk("mid.out_valid", 32'(out_valid), 32'd1);
        chk("mid.rs_data", ex_rs_data, 32'hABC);
        @(negedge clk) rst_n = 1'b0;
        #1;
        chk("midrst.out_valid", 32'(out_valid), 32'd0);
        chk("midrst.ctrl", 32'(ex_ctrl), 32'd0);
        chk("midrst.rs_data", ex_rs_data, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        tick();
        chk("post.out_valid", 32'(out_valid), 32'd1);
        chk("post.r5", ex_rs_data, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
